// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, FSM
// state type, the latched request record, and lane/alignment helpers.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC1,
        ST_ACC2,
        ST_RESP
    } lsu_state_t;

    // Request fields that must survive past the accept cycle.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } lsu_req_t;

    // Byte-lane mask over two consecutive words: [3:0] first word, [7:4] next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    // True when the access crosses a word boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
    endfunction

    // Offset of the last accessed byte relative to the start address.
    function automatic logic [1:0] last_off(input logic [1:0] size);
        case (size)
            SZ_H:    return 2'd1;
            SZ_W:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: merges the low/high memory words, shifts the addressed
// bytes down to bit 0 and sign- or zero-extends byte/half results.
// Ports: lo_word/hi_word (first/next memory word), off (addr[1:0]),
//        size, uns (zero-extend), ld_data_c (combinational result).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ld_data_c
);

    logic [63:0] merged;
    logic [31:0] shifted;

    always_comb begin
        merged  = {hi_word, lo_word};
        shifted = 32'(merged >> {off, 3'b000});
        case (size)
            SZ_B:    ld_data_c = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data_c = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data_c = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// CPU-side load/store unit driving the data memory port. Accepts one request
// at a time, performs one (or, when split, two) word accesses and returns a
// single response held until resp_ready.
// Ports: clk, reset (async, active-high); req_* request handshake and payload;
//        resp_* response handshake and data; daddr/dwdata/dwe/drdata memory port.
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses
// over two memory cycles; otherwise such accesses return resp_err.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);

    lsu_state_t  state, state_d;
    lsu_req_t    req_q, req_d;
    logic        req_ready_d, resp_valid_d, resp_err_d;
    logic [31:0] resp_rdata_d, daddr_d, dwdata_d;
    logic [3:0]  dwe_d;

    logic        out_of_range, acc_bad;
    logic [31:0] st_lo;
    logic [3:0]  st_lo_we;
    logic [31:0] lo_word_c;
    logic [31:0] ld_data_c;

    // Range check on the last accessed byte, with a carry bit so wrap cannot hide it.
    assign out_of_range = ({1'b0, req_addr} + 33'(last_off(req_size))) >= {1'b0, ADDR_LIMIT};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        is_split, split_q, split_d;
    logic [31:0] nxt_daddr, nxt_daddr_d, hi_dwdata, hi_dwdata_d, lo_word, lo_word_d;
    logic [3:0]  hi_dwe, hi_dwe_d;
    logic [63:0] st_wide;
    logic [7:0]  st_mask;

    assign is_split  = misaligned(req_size, req_addr[1:0]);
    assign acc_bad   = (req_size == 2'b11) || out_of_range;
    assign st_wide   = 64'(req_wdata) << {req_addr[1:0], 3'b000};
    assign st_mask   = lane_mask(req_size, req_addr[1:0]);
    assign st_lo     = st_wide[31:0];
    assign st_lo_we  = st_mask[3:0];
    // During ACC2 the first word comes from the capture taken at the end of ACC1.
    assign lo_word_c = (state == ST_ACC1) ? drdata : lo_word;
`else
    assign acc_bad   = (req_size == 2'b11) || out_of_range || misaligned(req_size, req_addr[1:0]);
    assign st_lo     = req_wdata << {req_addr[1:0], 3'b000};
    assign st_lo_we  = 4'(lane_mask(req_size, req_addr[1:0]));
    assign lo_word_c = drdata;
`endif

    lsu_load_align u_align (
        .lo_word   (lo_word_c),
        .hi_word   (drdata),
        .off       (req_q.off),
        .size      (req_q.size),
        .uns       (req_q.uns),
        .ld_data_c (ld_data_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        req_d        = req_q;
        req_ready_d  = 1'b0;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        daddr_d      = daddr;
        dwdata_d     = dwdata;
        dwe_d        = 4'b0000;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d      = split_q;
        nxt_daddr_d  = nxt_daddr;
        hi_dwdata_d  = hi_dwdata;
        hi_dwe_d     = hi_dwe;
        lo_word_d    = lo_word;
`endif
        case (state)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    req_d.we    = req_we;
                    req_d.size  = req_size;
                    req_d.uns   = req_unsigned;
                    req_d.off   = req_addr[1:0];
                    if (acc_bad) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d  = ST_ACC1;
                        daddr_d  = {req_addr[31:2], 2'b00};
                        dwdata_d = st_lo;
                        dwe_d    = req_we ? st_lo_we : 4'b0000;
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_d     = is_split;
                        nxt_daddr_d = {req_addr[31:2] + 30'd1, 2'b00};
                        hi_dwdata_d = st_wide[63:32];
                        hi_dwe_d    = req_we ? st_mask[7:4] : 4'b0000;
`endif
                    end
                end
            end
            ST_ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    state_d   = ST_ACC2;
                    daddr_d   = nxt_daddr;
                    dwdata_d  = hi_dwdata;
                    dwe_d     = hi_dwe;
                    lo_word_d = drdata;
                end else
`endif
                begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = req_q.we ? '0 : ld_data_c;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC2: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = req_q.we ? '0 : ld_data_c;
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            daddr      <= '0;
            dwdata     <= '0;
            dwe        <= 4'b0000;
        end else begin
            state      <= state_d;
            req_q      <= req_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            daddr      <= daddr_d;
            dwdata     <= dwdata_d;
            dwe        <= dwe_d;
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Second-word context for split accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            split_q   <= 1'b0;
            nxt_daddr <= '0;
            hi_dwdata <= '0;
            hi_dwe    <= 4'b0000;
            lo_word   <= '0;
        end else begin
            split_q   <= split_d;
            nxt_daddr <= nxt_daddr_d;
            hi_dwdata <= hi_dwdata_d;
            hi_dwe    <= hi_dwe_d;
            lo_word   <= lo_word_d;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: directed requests against a 16KB word memory
// model; expected responses queued at issue and checked by a monitor.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, daddr, dwdata, drdata;
    logic [3:0]  dwe;

    lsu_dmem_master dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .daddr        (daddr),
        .dwdata       (dwdata),
        .dwe          (dwe),
        .drdata       (drdata)
    );

    always #5 clk = ~clk;

    // Data memory model
    logic [31:0] mem [0:4095];
    logic        mem_init;
    assign drdata = mem[daddr[13:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[12'h040] <= 32'h8899AABB;
            mem[12'h041] <= 32'h11223344;
        end else begin
            for (int i = 0; i < 4; i++)
                if (dwe[i]) mem[daddr[13:2]][8*i +: 8] <= dwdata[8*i +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    logic seen = 1'b0;
    int   lat_obs = 0;

    // Response monitor: logs accept cycles, measures latency, pops and compares.
    always @(negedge clk) begin
        if (reset) begin
            acc_q.delete();
            seen = 1'b0;
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc + 1);
            if (resp_valid && !seen) begin
                seen = 1'b1;
                if (acc_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL resp_without_accept: resp_valid=1 required no response");
                    lat_obs = -1;
                end else begin
                    lat_obs = cyc - acc_q.pop_front() + 1;
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_resp: rdata=0x%08h with no request outstanding", resp_rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_latency", 32'(lat_obs), 32'(e.lat));
                end
                seen = 1'b0;
            end
        end
    end

    logic [31:0] b_addr [3];
    logic [3:0]  b_we   [3];
    logic [31:0] b_wd   [3];

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready=0 required 1");
        end
    endtask

    // Issue one request, record the memory port for the following three cycles.
    task automatic issue(input logic we, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int el);
        exp_t e;
        e.rdata = er; e.err = ee; e.lat = el;
        exp_q.push_back(e);
        req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_addr[i] = daddr; b_we[i] = dwe; b_wd[i] = dwdata;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: %0d responses still pending, required 0", exp_q.size());
        end
    endtask

    task automatic run(input logic we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int el);
        issue(we, sz, un, a, wd, er, ee, el);
        wait_idle();
    endtask

    function automatic logic [31:0] no_writes();
        return 32'(b_we[0] | b_we[1] | b_we[2]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_daddr", daddr, 32'h0);
        check("rst_dwdata", dwdata, 32'h0);
        check("rst_dwe", 32'(dwe), 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("idle_req_ready", 32'(req_ready), 32'h1);

        // Aligned loads
        run(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        check("lb_daddr", b_addr[0], 32'h100);
        check("lb_no_dwe", no_writes(), 32'h0);
        run(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h000000AA, 1'b0, 2);
        run(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2);
        run(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 2);

        // Word load crossing a word boundary
`ifdef LSU_MISALIGN_SPLIT_EN
        run(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h33448899, 1'b0, 3);
        check("split_lw_daddr0", b_addr[0], 32'h100);
        check("split_lw_daddr1", b_addr[1], 32'h104);
`else
        run(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
`endif
        check("split_lw_no_dwe", no_writes(), 32'h0);

        // Byte and half stores
        run(1'b1, 2'b00, 1'b0, 32'h103, 32'h55, 32'h0, 1'b0, 2);
        check("sb_daddr", b_addr[0], 32'h100);
        check("sb_dwe", 32'(b_we[0]), 32'h8);
        check("sb_dwdata", b_wd[0], 32'h55000000);
        check("sb_dwe_after", 32'(b_we[1]), 32'h0);
        run(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h5599AABB, 1'b0, 2);
        run(1'b1, 2'b01, 1'b0, 32'h10A, 32'hCAFE, 32'h0, 1'b0, 2);
        check("sh_daddr", b_addr[0], 32'h108);
        check("sh_dwe", 32'(b_we[0]), 32'hC);
        check("sh_dwdata", b_wd[0], 32'hCAFE0000);
        run(1'b0, 2'b01, 1'b0, 32'h10A, 32'h0, 32'hFFFFCAFE, 1'b0, 2);
        run(1'b0, 2'b01, 1'b1, 32'h10A, 32'h0, 32'h0000CAFE, 1'b0, 2);

        // Errors and range boundary
        run(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1);
        check("oor_lw_no_dwe", no_writes(), 32'h0);
        run(1'b1, 2'b10, 1'b0, 32'h4000, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        check("oor_sw_no_dwe", no_writes(), 32'h0);
        run(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        check("badsize_no_dwe", no_writes(), 32'h0);
        run(1'b0, 2'b00, 1'b0, 32'h3FFF, 32'h0, 32'h0, 1'b0, 2);
        run(1'b0, 2'b01, 1'b0, 32'h3FFF, 32'h0, 32'h0, 1'b1, 1);

        // Word store crossing a word boundary
`ifdef LSU_MISALIGN_SPLIT_EN
        run(1'b1, 2'b10, 1'b0, 32'h10D, 32'h44332211, 32'h0, 1'b0, 3);
        check("split_sw_daddr0", b_addr[0], 32'h10C);
        check("split_sw_dwe0", 32'(b_we[0]), 32'hE);
        check("split_sw_dwdata0", b_wd[0], 32'h33221100);
        check("split_sw_daddr1", b_addr[1], 32'h110);
        check("split_sw_dwe1", 32'(b_we[1]), 32'h1);
        check("split_sw_dwdata1", b_wd[1], 32'h00000044);
        run(1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 32'h33221100, 1'b0, 2);
        run(1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 32'h00000044, 1'b0, 2);
`else
        run(1'b1, 2'b10, 1'b0, 32'h10D, 32'h44332211, 32'h0, 1'b1, 1);
        check("split_sw_no_dwe", no_writes(), 32'h0);
        run(1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 32'h0, 1'b0, 2);
        run(1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 32'h0, 1'b0, 2);
`endif

        // Response backpressure with a second request waiting
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h5599AABB, 1'b0, 2);
        begin
            exp_t e;
            e.rdata = 32'h000000AA; e.err = 1'b0; e.lat = 2;
            exp_q.push_back(e);
        end
        req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h101; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 32'(resp_valid), 32'h1);
            check("hold_resp_rdata", resp_rdata, 32'h5599AABB);
            check("hold_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_req_ready", 32'(req_ready), 32'h1);
        check("post_hs_resp_valid", 32'(resp_valid), 32'h0);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a store
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_addr = 32'h103; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1 req_valid = 1'b0;
        check("rst_acc1_dwe", 32'(dwe), 32'h8);
        @(posedge clk); #1;
        check("rst_acc2_daddr", daddr, 32'h104);
        check("rst_acc2_dwe", 32'(dwe), 32'h7);
`else
        req_addr = 32'h104; req_wdata = 32'h12345678; req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1 req_valid = 1'b0;
        check("rst_acc1_dwe", 32'(dwe), 32'hF);
`endif
        reset = 1'b1;
        #1;
        check("mid_rst_dwe", 32'(dwe), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        check("mid_rst_daddr", daddr, 32'h0);
        check("mid_rst_dwdata", dwdata, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
`ifdef LSU_MISALIGN_SPLIT_EN
        run(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFFEF, 1'b0, 2);
`else
        run(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h00000055, 1'b0, 2);
`endif
        run(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h11223344, 1'b0, 2);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
